// File: rtl/pq_arbiter.sv
// pq_arbiter: round-robin arbiter serialising POP/REPLACE requests from
// NUM_REQ requesters onto a single register-array priority queue. Each
// accepted request returns the queue maximum seen at grant time through a
// valid/ready response port.
module pq_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NUM_REQ-1:0]                             req_valid,
  input  logic [NUM_REQ-1:0]                             req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]                  req_data,
  output logic [NUM_REQ-1:0]                             req_ready,
  output logic                                           resp_valid,
  input  logic                                           resp_ready,
  output logic [DATA_WIDTH-1:0]                          resp_data,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] resp_id,
  output logic                                           resp_err,
  output logic                                           q_replace,
  output logic [DATA_WIDTH-1:0]                          q_new_entry,
  input  logic [DATA_WIDTH-1:0]                          q_max_entry
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [CNT_W-1:0]      r_settle_cnt;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic [ID_W-1:0]       r_resp_id;
  logic                  r_resp_err;

  logic                  w_grant_any;
  logic [ID_W-1:0]       w_grant_idx;
  logic [NUM_REQ-1:0]    w_grant_vec;
  logic [ID_W-1:0]       w_rr_nxt;
  logic [DATA_WIDTH-1:0] w_req_entry;
  logic                  w_write_data;
  logic                  w_do_write;
  logic                  w_grant_fire;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  // Iterating from the farthest offset down lets the nearest one win last.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req_valid[ID_W'((int'(r_rr_ptr) + off) % NUM_REQ)]) begin
        w_grant_any = 1'b1;
        w_grant_idx = ID_W'((int'(r_rr_ptr) + off) % NUM_REQ);
      end
    end
  end

  assign w_grant_vec  = w_grant_any ? (NUM_REQ'(1) << w_grant_idx) : '0;
  assign w_rr_nxt     = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
  assign w_req_entry  = req_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
  // A REPLACE of 0 behaves exactly like a POP; only nonzero data is inserted.
  assign w_write_data = req_op[w_grant_idx] && (w_req_entry != '0);
  assign w_do_write   = w_write_data || (q_max_entry != '0);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and grant-cycle outputs (ready, queue write strobe).
  always_comb begin
    w_state_nxt  = r_state;
    req_ready    = '0;
    q_replace    = 1'b0;
    q_new_entry  = '0;
    w_grant_fire = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_any) begin
          req_ready    = w_grant_vec;
          w_grant_fire = 1'b1;
          if (w_do_write) begin
            q_replace   = 1'b1;
            q_new_entry = w_write_data ? w_req_entry : '0;
            w_state_nxt = ST_SETTLE;
          end else begin
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_SETTLE: if (r_settle_cnt == '0) w_state_nxt = ST_RESP;
      ST_RESP:   if (resp_ready)          w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    // Reset masks the combinational handshake so nothing is accepted while
    // the block is being cleared.
    if (rst) begin
      req_ready    = '0;
      q_replace    = 1'b0;
      q_new_entry  = '0;
      w_grant_fire = 1'b0;
    end
  end

  // Settle down-counter: loaded on a queue write, drained while in SETTLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle_cnt <= '0;
    end else if (w_grant_fire && w_do_write) begin
      r_settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
    end else if (r_state == ST_SETTLE && r_settle_cnt != '0) begin
      r_settle_cnt <= r_settle_cnt - 1'b1;
    end
  end

  // Grant bookkeeping: advance the pointer and capture the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_resp_data <= '0;
      r_resp_id   <= '0;
      r_resp_err  <= 1'b0;
    end else if (w_grant_fire) begin
      r_rr_ptr    <= w_rr_nxt;
      r_resp_data <= w_do_write ? q_max_entry : '0;
      r_resp_id   <= w_grant_idx;
      r_resp_err  <= ~w_do_write;
    end
  end

  assign resp_valid = (r_state == ST_RESP) && !rst;
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;
  assign resp_err   = r_resp_err;

endmodule
